// File: rtl/pbit_anneal_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pbit_anneal_scheduler: Gibbs-order p-bit update strobes + beta annealing  |
// | ramp (ramp enabled by macro PBIT_ANNEAL_EN).   Rev 1.0                     |
// +--------------------------------------------------------------------------+
module pbit_anneal_scheduler #(
    parameter int N_PBITS         = 8,
    parameter int SETTLE          = 4,
    parameter int SWEEPS_PER_STEP = 16,
    parameter int STEP_W          = 16,
    parameter int BETA_W          = 16
) (
    input  logic                        clk_mac,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic signed [BETA_W-1:0]    beta_init,
    input  logic signed [BETA_W-1:0]    beta_step,
    input  logic signed [BETA_W-1:0]    beta_max,
    input  logic [STEP_W-1:0]           num_steps,
    output logic [N_PBITS-1:0]          upd_en,
    output logic [$clog2(N_PBITS)-1:0]  upd_idx,
    output logic signed [BETA_W-1:0]    o_beta,
    output logic                        busy,
    output logic                        done,
    output logic [STEP_W-1:0]           sweep_cnt
);

    localparam int IDX_W = $clog2(N_PBITS);
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETTLE = 2'd1;
    localparam logic [1:0] c_STROBE = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    localparam logic [CNT_W-1:0]  c_CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0]  c_IDX_LAST = IDX_W'(N_PBITS - 1);
    localparam logic [STEP_W-1:0] c_SPS_LAST = STEP_W'(SWEEPS_PER_STEP - 1);

    logic [1:0]               r_state;
    logic                     r_start_q;
    logic [CNT_W-1:0]         r_cnt;
    logic [N_PBITS-1:0]       r_upd_en;
    logic [IDX_W-1:0]         r_upd_idx;
    logic signed [BETA_W-1:0] r_beta;
    logic                     r_busy;
    logic                     r_done;
    logic [STEP_W-1:0]        r_sweep_cnt;
    logic [STEP_W-1:0]        r_sps_cnt;
    logic [STEP_W-1:0]        r_step_cnt;
    logic [STEP_W-1:0]        r_num_steps;

    logic [STEP_W-1:0]        w_step_nxt;
    logic signed [BETA_W-1:0] w_beta_nxt;

    assign w_step_nxt = r_step_cnt + 1'b1;

`ifdef PBIT_ANNEAL_EN
    // One extra bit so a positive overflow still compares above beta_max.
    logic signed [BETA_W:0] w_sum;
    assign w_sum      = $signed({r_beta[BETA_W-1], r_beta}) + $signed({beta_step[BETA_W-1], beta_step});
    assign w_beta_nxt = (w_sum > $signed({beta_max[BETA_W-1], beta_max})) ? beta_max : w_sum[BETA_W-1:0];
`else
    logic w_unused_beta;
    assign w_unused_beta = ^{beta_step, beta_max};
    assign w_beta_nxt    = r_beta;
`endif

    always_ff @(posedge clk_mac) begin
        if (!reset_n) begin
            r_state     <= c_IDLE;
            r_start_q   <= 1'b0;
            r_cnt       <= '0;
            r_upd_en    <= '0;
            r_upd_idx   <= '0;
            r_beta      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sweep_cnt <= '0;
            r_sps_cnt   <= '0;
            r_step_cnt  <= '0;
            r_num_steps <= '0;
        end else if (abort && (r_state != c_IDLE)) begin
            r_state   <= c_IDLE;
            r_start_q <= 1'b0;
            r_cnt     <= '0;
            r_upd_en  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_start_q <= start;
            r_done    <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_upd_en <= '0;
                    if (r_start_q) begin
                        if (num_steps != '0) begin
                            r_beta      <= beta_init;
                            r_upd_idx   <= '0;
                            r_sweep_cnt <= '0;
                            r_sps_cnt   <= '0;
                            r_step_cnt  <= '0;
                            r_num_steps <= num_steps;
                            r_cnt       <= '0;
                            r_busy      <= 1'b1;
                            r_state     <= c_SETTLE;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= c_DONE;
                        end
                    end
                end
                c_SETTLE: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt    <= '0;
                        r_upd_en <= N_PBITS'(1) << r_upd_idx;
                        r_state  <= c_STROBE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_STROBE: begin
                    r_upd_en <= '0;
                    r_state  <= c_SETTLE;
                    if (r_upd_idx != c_IDX_LAST) begin
                        r_upd_idx <= r_upd_idx + 1'b1;
                    end else begin
                        r_upd_idx   <= '0;
                        r_sweep_cnt <= r_sweep_cnt + 1'b1;
                        if (r_sps_cnt == c_SPS_LAST) begin
                            // Step boundary: beta moves while the next SETTLE window runs.
                            r_sps_cnt  <= '0;
                            r_step_cnt <= w_step_nxt;
                            r_beta     <= w_beta_nxt;
                            if (w_step_nxt == r_num_steps) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= c_DONE;
                            end
                        end else begin
                            r_sps_cnt <= r_sps_cnt + 1'b1;
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign upd_en    = r_upd_en;
    assign upd_idx   = r_upd_idx;
    assign o_beta    = r_beta;
    assign busy      = r_busy;
    assign done      = r_done;
    assign sweep_cnt = r_sweep_cnt;

endmodule
`default_nettype wire
